ling_add_arbiter: RTL and testbench

LING_ADD_ARBITER -- requirements
Module: ling_add_arbiter

---
 rtl/ling_add_arbiter.sv | 255 +++++++++++++++++++++++++
 tb/tb_ling_add_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ling_add_arbiter.sv
// ling_add_arbiter: round-robin arbiter that feeds N_REQ requesters into one
// shared 32-bit Ling adder through a two-stage (A -> adder -> B) pipeline
// with valid/ready flow control on both sides.
//
// ling_adder32: combinational 32-bit sparse-4 Ling adder. Group Ling
// pseudo-carries are combined by a 3-level Kogge-Stone tree over eight 4-bit
// groups; each group then resolves its own bit carries from the group carry-in.

module ling_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  logic [31:0] g;
  logic [31:0] t;
  logic [31:0] p;

  assign g = a & b;
  assign t = a | b;
  assign p = a ^ b;

  // Group pseudo-generate (Ling H) and transmit terms. The transmit term of
  // group gi reaches one bit down (t[4gi-1]) because the real carry is t & H.
  logic [7:0] grp_h;
  logic [7:0] grp_p;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_grp
      assign grp_h[gi] = g[4*gi+3] | g[4*gi+2]
                       | (t[4*gi+2] & g[4*gi+1])
                       | (t[4*gi+2] & t[4*gi+1] & g[4*gi]);
      if (gi == 0) begin : g_first
        assign grp_p[gi] = t[2] & t[1] & t[0];
      end else begin : g_rest
        assign grp_p[gi] = t[4*gi+2] & t[4*gi+1] & t[4*gi] & t[4*gi-1];
      end
    end
  endgenerate

  // Kogge-Stone prefix over the eight groups: distances 1, 2 and 4.
  logic [7:0] h1, p1, h2, p2, h3;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lvl1
      if (gi >= 1) begin : g_op
        assign h1[gi] = grp_h[gi] | (grp_p[gi] & grp_h[gi-1]);
        assign p1[gi] = grp_p[gi] & grp_p[gi-1];
      end else begin : g_pass
        assign h1[gi] = grp_h[gi];
        assign p1[gi] = grp_p[gi];
      end
    end
    for (genvar gi = 0; gi < 8; gi++) begin : g_lvl2
      if (gi >= 2) begin : g_op
        assign h2[gi] = h1[gi] | (p1[gi] & h1[gi-2]);
        assign p2[gi] = p1[gi] & p1[gi-2];
      end else begin : g_pass
        assign h2[gi] = h1[gi];
        assign p2[gi] = p1[gi];
      end
    end
    for (genvar gi = 0; gi < 8; gi++) begin : g_lvl3
      if (gi >= 4) begin : g_op
        assign h3[gi] = h2[gi] | (p2[gi] & h2[gi-4]);
      end else begin : g_pass
        assign h3[gi] = h2[gi];
      end
    end
  endgenerate

  // Per-group sum: carry-in is t[4gi-1] & H(prefix of lower groups); inner
  // carries use the local Ling form c_k = t[k-1] & h_k.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_sum
      logic cin;
      logic hl1, hl2, hl3;
      logic c1, c2, c3;
      if (gi == 0) begin : g_cin0
        assign cin = 1'b0;
      end else begin : g_cinn
        assign cin = t[4*gi-1] & h3[gi-1];
      end
      assign hl1 = g[4*gi] | cin;
      assign hl2 = g[4*gi+1] | g[4*gi] | (t[4*gi] & cin);
      assign hl3 = g[4*gi+2] | g[4*gi+1] | (t[4*gi+1] & g[4*gi])
                 | (t[4*gi+1] & t[4*gi] & cin);
      assign c1 = t[4*gi]   & hl1;
      assign c2 = t[4*gi+1] & hl2;
      assign c3 = t[4*gi+2] & hl3;
      assign sum[4*gi]   = p[4*gi]   ^ cin;
      assign sum[4*gi+1] = p[4*gi+1] ^ c1;
      assign sum[4*gi+2] = p[4*gi+2] ^ c2;
      assign sum[4*gi+3] = p[4*gi+3] ^ c3;
    end
  endgenerate

endmodule

module ling_add_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_sum,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          op_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STALL} st_t;

  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(N_REQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

  st_t             st;
  logic            va_q, va_d, vb_q, vb_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [IDW-1:0]  ida_q, ida_d, idb_q, idb_d;
  logic [31:0]     sum_q, sum_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [31:0]     op_cnt_q, op_cnt_d;
  logic [31:0]     add_sum;
  logic            stall_a, stall_b;
  logic            found;
  logic            accept;
  logic [IDW-1:0]  gnt_id;
  logic [N_REQ-1:0] gnt_oh;
  logic [31:0]     op_a [N_REQ];
  logic [31:0]     op_b [N_REQ];

  // Unpack the flat operand buses into per-requester words.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign op_a[gi] = req_a[32*gi +: 32];
      assign op_b[gi] = req_b[32*gi +: 32];
    end
  endgenerate

  // The single shared adder sits between stage A and stage B.
  ling_adder32 u_adder (
    .a   (a_q),
    .b   (b_q),
    .sum (add_sum)
  );

  // State decode: sequencing state follows pipeline occupancy and rsp_ready.
  always_comb begin
    if (!va_q && !vb_q) begin
      st = ST_IDLE;
    end else if (vb_q && !rsp_ready) begin
      st = ST_STALL;
    end else begin
      st = ST_RUN;
    end
  end

  assign stall_b = (st == ST_STALL);
  assign stall_a = va_q && stall_b;

  // Round-robin search: first valid requester at ptr, ptr+1, ... mod N_REQ.
  always_comb begin
    logic [IDW:0] srch;
    srch   = '0;
    found  = 1'b0;
    gnt_id = '0;
    // Walk from the far end so the nearest hit to ptr is the one kept.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      srch = {1'b0, ptr_q} + (IDW+1)'(k);
      if (srch >= NREQ_W) begin
        srch = srch - NREQ_W;
      end
      if (req_valid[srch[IDW-1:0]]) begin
        found  = 1'b1;
        gnt_id = srch[IDW-1:0];
      end
    end
  end

  // Output decode: one-hot ready on the grantee, silenced by stall or reset.
  always_comb begin
    gnt_oh = '0;
    if (found && !stall_a && !rst) begin
      gnt_oh[gnt_id] = 1'b1;
    end
  end

  assign req_ready = gnt_oh;
  assign accept    = |(req_valid & req_ready);

  // Next-state for both pipeline stages, pointer and operation counter.
  always_comb begin
    va_d     = va_q;
    a_d      = a_q;
    b_d      = b_q;
    ida_d    = ida_q;
    ptr_d    = ptr_q;
    op_cnt_d = op_cnt_q;
    vb_d     = vb_q;
    sum_d    = sum_q;
    idb_d    = idb_q;
    if (!stall_a) begin
      va_d = accept;
      if (accept) begin
        a_d      = op_a[gnt_id];
        b_d      = op_b[gnt_id];
        ida_d    = gnt_id;
        ptr_d    = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
        op_cnt_d = op_cnt_q + 32'd1;
      end
    end
    if (!stall_b) begin
      vb_d  = va_q;
      sum_d = add_sum;
      idb_d = ida_q;
    end
  end

  // Pipeline, pointer and counter registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      va_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ida_q    <= '0;
      vb_q     <= 1'b0;
      sum_q    <= '0;
      idb_q    <= '0;
      ptr_q    <= '0;
      op_cnt_q <= '0;
    end else begin
      va_q     <= va_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ida_q    <= ida_d;
      vb_q     <= vb_d;
      sum_q    <= sum_d;
      idb_q    <= idb_d;
      ptr_q    <= ptr_d;
      op_cnt_q <= op_cnt_d;
    end
  end

  assign rsp_valid = vb_q;
  assign rsp_sum   = sum_q;
  assign rsp_id    = idb_q;
  assign op_count  = op_cnt_q;

endmodule

// File: tb/tb_ling_add_arbiter.sv
// Directed bench for ling_add_arbiter (N_REQ=4): grant order, latency,
// stall/drain, reset mid-flight and counter wrap.

module tb_ling_add_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_sum;
  logic [1:0]   rsp_id;
  logic [31:0]  op_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ling_add_arbiter #(.N_REQ(4), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .op_count  (op_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic load_default_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = 32'h100 * (i + 1);
      req_b[32*i +: 32] = i + 1;
    end
  endtask

  // One line per request or response transfer.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          $display("%0t accept id=%0d a=%08h b=%08h", $time, i, req_a[32*i +: 32], req_b[32*i +: 32]);
        end
      end
      if (rsp_valid && rsp_ready) begin
        $display("%0t response id=%0d sum=%08h", $time, rsp_id, rsp_sum);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    load_default_ops();
    #2;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_op_count", op_count, 0);
    chk("reset_rsp_sum", rsp_sum, 0);
    chk("reset_rsp_id", rsp_id, 0);

    // All four requesters continuously valid: 0,1,2,3,0,1,2,3.
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      if (c == 0) begin
        req_valid = 4'hF;
        rsp_ready = 1'b1;
      end
      if (c == 8) req_valid = 4'h0;
      #1;
      if (c < 8) chk("rr_grant", req_ready, 32'd1 << (c % 4));
      if (c >= 2 && c <= 9) begin
        chk("rr_rsp_valid", rsp_valid, 1);
        chk("rr_rsp_id", rsp_id, (c - 2) % 4);
        chk("rr_rsp_sum", rsp_sum, 32'h101 * (((c - 2) % 4) + 1));
      end
      if (c == 10) begin
        chk("rr_drained", rsp_valid, 0);
        chk("rr_op_count", op_count, 8);
      end
      @(negedge clk);
    end

    // Fresh reset, then carry wrap: FFFFFFFF + 1 from requester 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_a[31:0] = 32'hFFFF_FFFF;
    req_b[31:0] = 32'h0000_0001;
    req_valid   = 4'h1;
    #1;
    chk("wrap_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 4'h0;
    #1;
    chk("wrap_stage_a_only", rsp_valid, 0);
    chk("wrap_op_count_early", op_count, 1);
    @(negedge clk);
    #1;
    chk("wrap_rsp_valid", rsp_valid, 1);
    chk("wrap_rsp_sum", rsp_sum, 32'h0000_0000);
    chk("wrap_rsp_id", rsp_id, 0);
    chk("wrap_op_count", op_count, 1);
    @(negedge clk);
    #1;
    chk("wrap_drained", rsp_valid, 0);

    // Only requester 2, back-to-back identical operands.
    req_a[95:64] = 32'h1234_5678;
    req_b[95:64] = 32'h9ABC_DEF0;
    @(negedge clk);
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) req_valid = 4'h4;
      if (c == 3) req_valid = 4'h0;
      #1;
      if (c < 3) chk("solo_ready", req_ready, 4);
      if (c == 3) chk("solo_ready_idle", req_ready, 0);
      if (c >= 2 && c <= 4) begin
        chk("solo_rsp_valid", rsp_valid, 1);
        chk("solo_rsp_sum", rsp_sum, 32'hACF1_3568);
        chk("solo_rsp_id", rsp_id, 2);
      end
      if (c == 5) begin
        chk("solo_drained", rsp_valid, 0);
        chk("solo_op_count", op_count, 4);
      end
      @(negedge clk);
    end

    // Backpressure: two accepted, then ready drops; drain in order.
    load_default_ops();
    rsp_ready = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      if (c == 0) req_valid = 4'hF;
      if (c == 4) begin
        rsp_ready = 1'b1;
        req_valid = 4'h0;
      end
      #1;
      if (c == 0) chk("bp_first_grant", req_ready, 8);
      if (c == 1) begin
        chk("bp_second_grant", req_ready, 1);
        chk("bp_not_yet_valid", rsp_valid, 0);
      end
      if (c == 2 || c == 3) begin
        chk("bp_ready_blocked", req_ready, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_rsp_id_stable", rsp_id, 3);
        chk("bp_rsp_sum_stable", rsp_sum, 32'h404);
      end
      if (c == 3) chk("bp_op_count", op_count, 6);
      if (c == 4) begin
        chk("bp_drain0_id", rsp_id, 3);
        chk("bp_drain0_sum", rsp_sum, 32'h404);
      end
      if (c == 5) begin
        chk("bp_drain1_valid", rsp_valid, 1);
        chk("bp_drain1_id", rsp_id, 0);
        chk("bp_drain1_sum", rsp_sum, 32'h101);
      end
      if (c == 6) begin
        chk("bp_drained", rsp_valid, 0);
        chk("bp_op_count_final", op_count, 6);
      end
      @(negedge clk);
    end

    // Fill both stages, then reset between edges.
    rsp_ready = 1'b0;
    req_valid = 4'h1;
    #1;
    chk("rst_fill_grant0", req_ready, 1);
    @(negedge clk);
    #1;
    chk("rst_fill_grant1", req_ready, 1);
    @(negedge clk);
    #1;
    chk("rst_full_valid", rsp_valid, 1);
    req_valid = 4'hA;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", rsp_valid, 0);
    chk("rst_async_ready", req_ready, 0);
    chk("rst_async_count", op_count, 0);
    chk("rst_async_sum", rsp_sum, 0);
    chk("rst_async_id", rsp_id, 0);
    @(negedge clk);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("rst_after_grant1", req_ready, 2);
    @(negedge clk);
    #1;
    chk("rst_after_grant3", req_ready, 8);
    @(negedge clk);
    req_valid = 4'h0;
    #1;
    chk("rst_after_rsp1_id", rsp_id, 1);
    chk("rst_after_rsp1_sum", rsp_sum, 32'h202);
    @(negedge clk);
    #1;
    chk("rst_after_rsp3_id", rsp_id, 3);
    chk("rst_after_rsp3_sum", rsp_sum, 32'h404);
    chk("rst_after_count", op_count, 2);
    @(negedge clk);
    #1;
    chk("rst_after_drained", rsp_valid, 0);

    // Counter wrap via backdoor load.
    @(negedge clk);
    dut.op_cnt_q = 32'hFFFF_FFFF;
    req_a[31:0]  = 32'd5;
    req_b[31:0]  = 32'd7;
    req_valid    = 4'h1;
    #1;
    chk("cnt_preload", op_count, 32'hFFFF_FFFF);
    chk("cnt_grant", req_ready, 1);
    @(negedge clk);
    req_valid = 4'h0;
    #1;
    chk("cnt_wrapped", op_count, 32'h0000_0000);
    @(negedge clk);
    #1;
    chk("cnt_rsp_sum", rsp_sum, 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
